// File: rtl/arg_cmd_pkg.sv
// rtl/arg_cmd_pkg.sv - register map, command/status bit positions and FSM state type.
package arg_cmd_pkg;

   localparam int ADDR_CMD        = 0;
   localparam int ADDR_STATUS     = 1;
   localparam int ADDR_ARGIN_BASE = 2;

   localparam int CMD_RUN_BIT     = 0;
   localparam int CMD_ABORT_BIT   = 1;
   localparam int STAT_DONE_BIT   = 0;
   localparam int STAT_BUSY_BIT   = 1;
   localparam int STAT_CLR_BIT    = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int argout_base(input int num_arg_ins);
      return ADDR_ARGIN_BASE + num_arg_ins;
   endfunction

endpackage

// File: rtl/arg_regfile.sv
// rtl/arg_regfile.sv - argIn/argOut storage with address decode and read-side lookup.
module arg_regfile import arg_cmd_pkg::*; #(
   parameter int NUM_ARG_INS  = 2,
   parameter int NUM_ARG_OUTS = 1,
   parameter int ADDR_W       = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      i_wr_en,
   input  logic [ADDR_W-1:0]         i_addr,
   input  logic [31:0]               i_wdata,
   input  logic                      i_argin_lock,
   input  logic                      i_capture,
   input  logic [NUM_ARG_OUTS*32-1:0] i_arg_outs,
   output logic [NUM_ARG_INS*32-1:0] o_arg_ins,
   output logic                      o_rd_hit,
   output logic [31:0]               o_rd_data
);

   logic [31:0] r_arg_in  [NUM_ARG_INS];
   logic [31:0] r_arg_out [NUM_ARG_OUTS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_ARG_INS; i++)  r_arg_in[i]  <= '0;
         for (int j = 0; j < NUM_ARG_OUTS; j++) r_arg_out[j] <= '0;
      end else begin
         if (i_wr_en && !i_argin_lock) begin
            for (int i = 0; i < NUM_ARG_INS; i++)
               if (i_addr == ADDR_W'(ADDR_ARGIN_BASE + i)) r_arg_in[i] <= i_wdata;
         end
         // argOuts only ever change on the accelerator's completion edge
         if (i_capture) begin
            for (int j = 0; j < NUM_ARG_OUTS; j++) r_arg_out[j] <= i_arg_outs[j*32 +: 32];
         end
      end
   end

   always_comb begin
      o_rd_hit  = 1'b0;
      o_rd_data = '0;
      for (int i = 0; i < NUM_ARG_INS; i++) begin
         if (i_addr == ADDR_W'(ADDR_ARGIN_BASE + i)) begin
            o_rd_hit  = 1'b1;
            o_rd_data = r_arg_in[i];
         end
      end
      for (int j = 0; j < NUM_ARG_OUTS; j++) begin
         if (i_addr == ADDR_W'(argout_base(NUM_ARG_INS) + j)) begin
            o_rd_hit  = 1'b1;
            o_rd_data = r_arg_out[j];
         end
      end
   end

   for (genvar g = 0; g < NUM_ARG_INS; g++) begin : g_pack
      assign o_arg_ins[g*32 +: 32] = r_arg_in[g];
   end

endmodule

// File: rtl/arg_cmd_ctrl.sv
// rtl/arg_cmd_ctrl.sv - Avalon-MM command/status controller; RUN_CYCLE_CNT_EN adds a RUN cycle counter.
module arg_cmd_ctrl import arg_cmd_pkg::*; #(
   parameter int NUM_ARG_INS  = 2,
   parameter int NUM_ARG_OUTS = 1,
   parameter int ADDR_W       = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [ADDR_W-1:0]          io_S_AVALON_address,
   input  logic                       io_S_AVALON_chipselect,
   input  logic                       io_S_AVALON_write,
   input  logic                       io_S_AVALON_read,
   input  logic [31:0]                io_S_AVALON_writedata,
   output logic [31:0]                io_S_AVALON_readdata,
   output logic                       io_enable,
   input  logic                       io_done,
   output logic [NUM_ARG_INS*32-1:0]  io_argIns,
   input  logic [NUM_ARG_OUTS*32-1:0] io_argOuts,
   output logic                       io_busy
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_readdata;
   logic        w_wr, w_rd, w_cmd_wr, w_stat_wr;
   logic        w_in_run, w_capture;
   logic        w_rf_hit;
   logic [31:0] w_rf_data, w_status, w_rd_mux;

   // write wins over a simultaneous read, so readdata holds in that cycle
   assign w_wr      = io_S_AVALON_chipselect && io_S_AVALON_write;
   assign w_rd      = io_S_AVALON_chipselect && io_S_AVALON_read && !io_S_AVALON_write;
   assign w_cmd_wr  = w_wr && (io_S_AVALON_address == ADDR_W'(ADDR_CMD));
   assign w_stat_wr = w_wr && (io_S_AVALON_address == ADDR_W'(ADDR_STATUS));
   assign w_in_run  = (r_state == ST_RUN);
   assign w_capture = w_in_run && io_done;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_cmd_wr && io_S_AVALON_writedata[CMD_RUN_BIT]) w_next = ST_RUN;
         ST_RUN: begin
            if (io_done)                                              w_next = ST_DONE;
            else if (w_cmd_wr && io_S_AVALON_writedata[CMD_ABORT_BIT]) w_next = ST_IDLE;
         end
         ST_DONE: begin
            if (w_cmd_wr && io_S_AVALON_writedata[CMD_RUN_BIT])         w_next = ST_RUN;
            else if (w_stat_wr && io_S_AVALON_writedata[STAT_CLR_BIT]) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   assign io_enable = w_in_run;
   assign io_busy   = w_in_run;

   arg_regfile #(
      .NUM_ARG_INS  (NUM_ARG_INS),
      .NUM_ARG_OUTS (NUM_ARG_OUTS),
      .ADDR_W       (ADDR_W)
   ) u_regfile (
      .clock        (clock),
      .reset        (reset),
      .i_wr_en      (w_wr),
      .i_addr       (io_S_AVALON_address),
      .i_wdata      (io_S_AVALON_writedata),
      .i_argin_lock (w_in_run),
      .i_capture    (w_capture),
      .i_arg_outs   (io_argOuts),
      .o_arg_ins    (io_argIns),
      .o_rd_hit     (w_rf_hit),
      .o_rd_data    (w_rf_data)
   );

`ifdef RUN_CYCLE_CNT_EN
   localparam int ADDR_RUN_CNT = ADDR_ARGIN_BASE + NUM_ARG_INS + NUM_ARG_OUTS;
   logic [31:0] r_run_cnt;

   always_ff @(posedge clock) begin
      if (reset)                                r_run_cnt <= '0;
      else if (!w_in_run && w_next == ST_RUN)   r_run_cnt <= '0;
      else if (w_in_run && r_run_cnt != '1)     r_run_cnt <= r_run_cnt + 32'd1;
   end
`endif

   always_comb begin
      w_status                = '0;
      w_status[STAT_DONE_BIT] = (r_state == ST_DONE);
      w_status[STAT_BUSY_BIT] = w_in_run;
   end

   always_comb begin
      w_rd_mux = '0;
      if (io_S_AVALON_address == ADDR_W'(ADDR_CMD))         w_rd_mux = {31'b0, w_in_run};
      else if (io_S_AVALON_address == ADDR_W'(ADDR_STATUS)) w_rd_mux = w_status;
      else if (w_rf_hit)                                    w_rd_mux = w_rf_data;
`ifdef RUN_CYCLE_CNT_EN
      else if (io_S_AVALON_address == ADDR_W'(ADDR_RUN_CNT)) w_rd_mux = r_run_cnt;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset)     r_readdata <= '0;
      else if (w_rd) r_readdata <= w_rd_mux;
   end

   assign io_S_AVALON_readdata = r_readdata;

endmodule

// File: tb/tb_arg_cmd_ctrl.sv
// tb/tb_arg_cmd_ctrl.sv - scoreboard bench for arg_cmd_ctrl (RUN_CYCLE_CNT_EN aware).
module tb_arg_cmd_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  address;
   logic        chipselect, write, read;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        enable, done, busy;
   logic [63:0] arg_ins;
   logic [31:0] arg_outs;

   int n_checks = 0;
   int n_fail   = 0;
   int en_cnt;
   logic mon_acc;
   logic [31:0] cnt_exp;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } rd_exp_t;
   rd_exp_t exp_q[$];

   always #5 clock = ~clock;

   arg_cmd_ctrl #(.NUM_ARG_INS(2), .NUM_ARG_OUTS(1), .ADDR_W(8)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .io_S_AVALON_address    (address),
      .io_S_AVALON_chipselect (chipselect),
      .io_S_AVALON_write      (write),
      .io_S_AVALON_read       (read),
      .io_S_AVALON_writedata  (writedata),
      .io_S_AVALON_readdata   (readdata),
      .io_enable              (enable),
      .io_done                (done),
      .io_argIns              (arg_ins),
      .io_argOuts             (arg_outs),
      .io_busy                (busy)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic bus_idle();
      chipselect = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge clock);
      chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
      @(posedge clock);
      #1 bus_idle();
   endtask

   task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
      rd_exp_t e;
      @(negedge clock);
      chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
      e.exp = exp; e.name = nm;
      exp_q.push_back(e);
      @(posedge clock);
      #1 bus_idle();
   endtask

   // monitor: an accepted read yields readdata one edge later
   initial begin
      rd_exp_t e;
      forever begin
         @(posedge clock);
         mon_acc = chipselect && read && !write && !reset;
         @(negedge clock);
         if (mon_acc) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_read: got 0x%08h expected no read", readdata);
            end else begin
               e = exp_q.pop_front();
               check(e.name, readdata, e.exp);
            end
         end
      end
   end

   initial begin
      bus_idle();
      reset = 1'b1; done = 1'b0; arg_outs = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_enable", {31'b0, enable}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_readdata", readdata, 32'h0);
      check("rst_argin0", arg_ins[31:0], 32'h0);
      bus_read(8'd1, 32'h0, "rst_status");
      bus_read(8'd0, 32'h0, "rst_cmd");

      // 48-cycle run with done on the last RUN cycle
      bus_write(8'd2, 32'h4);
      bus_read(8'd2, 32'h4, "argin0_wr");
      arg_outs = 32'h10;
      bus_write(8'd0, 32'h1);
      en_cnt = 0;
      for (int k = 0; k < 48; k++) begin
         @(negedge clock);
         if (enable) en_cnt++;
         if (k == 47) done = 1'b1;
         @(posedge clock);
         #1 done = 1'b0;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (enable) en_cnt++;
      end
      check("enable_cycles", en_cnt, 32'd48);
      bus_read(8'd4, 32'h10, "argout0_capture");
      bus_read(8'd0, 32'h0, "cmd_done");
`ifdef RUN_CYCLE_CNT_EN
      cnt_exp = 32'd48;
`else
      cnt_exp = 32'd0;
`endif
      bus_read(8'd5, cnt_exp, "run_cnt");
      bus_read(8'd1, 32'h1, "status_done");
      check("argins_pack", arg_ins[31:0], 32'h4);

      // chipselect low read and write-over-read both leave readdata alone
      @(negedge clock);
      chipselect = 1'b0; read = 1'b1; address = 8'd4;
      @(posedge clock);
      #1 bus_idle();
      @(negedge clock);
      check("cs0_hold", readdata, 32'h1);
      chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 8'd3; writedata = 32'h77;
      @(posedge clock);
      #1 bus_idle();
      @(negedge clock);
      check("wr_over_rd_hold", readdata, 32'h1);
      check("argin1_wr", arg_ins[63:32], 32'h77);

      // clear done, restart, then exercise ignored writes and abort
      bus_write(8'd1, 32'h1);
      bus_read(8'd1, 32'h0, "status_clr");
      arg_outs = 32'h55;
      bus_write(8'd0, 32'h1);
      bus_read(8'd0, 32'h1, "cmd_run");
      bus_read(8'd1, 32'h2, "status_busy");
      bus_write(8'd2, 32'h9);
      bus_write(8'd4, 32'hDEAD);
      bus_write(8'd0, 32'h1);
      bus_read(8'd2, 32'h4, "argin_locked");
      bus_read(8'd0, 32'h1, "run_reissue_ignored");
      bus_write(8'd0, 32'h2);
      @(negedge clock);
      check("abort_enable", {31'b0, enable}, 32'h0);
      bus_read(8'd1, 32'h0, "abort_status");
      bus_read(8'd4, 32'h10, "abort_no_capture");

      // abort and done on the same edge: done wins
      bus_write(8'd0, 32'h1);
      @(negedge clock);
      chipselect = 1'b1; write = 1'b1; address = 8'd0; writedata = 32'h2; done = 1'b1;
      @(posedge clock);
      #1 begin bus_idle(); done = 1'b0; end
      bus_read(8'd1, 32'h1, "abort_done_status");
      bus_read(8'd4, 32'h55, "abort_done_capture");
      @(negedge clock);
      arg_outs = 32'h99; done = 1'b1;
      @(posedge clock);
      #1 done = 1'b0;
      bus_read(8'd4, 32'h55, "done_outside_run");

      // reset in the middle of a run
      bus_write(8'd0, 32'h1);
      @(negedge clock);
      check("pre_reset_enable", {31'b0, enable}, 32'h1);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("mid_rst_enable", {31'b0, enable}, 32'h0);
      check("mid_rst_busy", {31'b0, busy}, 32'h0);
      check("mid_rst_readdata", readdata, 32'h0);
      check("mid_rst_argin1", arg_ins[63:32], 32'h0);
      bus_read(8'd4, 32'h0, "mid_rst_argout");
      bus_read(8'd2, 32'h0, "mid_rst_argin0");
      bus_read(8'd1, 32'h0, "mid_rst_status");
      bus_read(8'h7F, 32'h0, "unmapped_7f");
      bus_read(8'd5, 32'h0, "mid_rst_cnt");

      for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clock);
      @(negedge clock);
      if (exp_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/arg_cmd_ctrl.md
ARG_CMD_CTRL -- requirements
Module: arg_cmd_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_ARG_INS, 2, number of 32-bit host-written argument registers.
  NUM_ARG_OUTS, 1, number of 32-bit accelerator-result registers.
  ADDR_W, 8, Avalon word-address width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock  in  1  single clock domain.
  reset  in  1  synchronous, active-high.
  io_S_AVALON_address  in  ADDR_W  register word address.
  io_S_AVALON_chipselect  in  1  qualifies read/write.
  io_S_AVALON_write  in  1  write strobe.
  io_S_AVALON_read  in  1  read strobe.
  io_S_AVALON_writedata  in  32  write data.
  io_S_AVALON_readdata  out  32  registered read data.
  io_enable  out  1  run enable to accelerator.
  io_done  in  1  accelerator completion pulse/level.
  io_argIns  out  NUM_ARG_INS*32  packed argIn registers, index 0 in LSBs.
  io_argOuts  in  NUM_ARG_OUTS*32  packed accelerator results.
  io_busy  out  1  high in RUN.

Function
REQ-003 Map SHALL be: 0 command, 1 status, 2..2+NUM_ARG_INS-1 argIns, next NUM_ARG_OUTS addresses argOuts; all other addresses unmapped.
REQ-004 Access SHALL occur only when chipselect=1; write has priority over read in the same cycle; readdata then holds.
REQ-005 Readdata SHALL update one cycle after an accepted read; unmapped reads return 0; readdata holds between reads.
REQ-006 FSM states SHALL be IDLE, RUN, DONE.
REQ-007 Command write with bit0=1 in IDLE or DONE SHALL enter RUN next edge, clearing status done.
REQ-008 io_enable and io_busy SHALL be 1 exactly while in RUN.
REQ-009 io_done=1 in RUN SHALL enter DONE and capture io_argOuts into argOut registers on that edge; io_done outside RUN is ignored.
REQ-010 Command write with bit1=1 (abort) in RUN SHALL return to IDLE without capturing argOuts; io_done in the same cycle wins (DONE, captured).
REQ-011 Command writes with bit0=1 in RUN SHALL be ignored.
REQ-012 Status read SHALL return {30'b0, busy, done}; writing status with bit0=1 in DONE SHALL clear done and enter IDLE.
REQ-013 Command read SHALL return {31'b0, state==RUN}.
REQ-014 ArgIn writes in RUN SHALL be ignored; argOut registers are host read-only (writes ignored).

Reset
REQ-015 On reset edge: state IDLE, all arg registers 0, readdata 0, io_enable 0, io_busy 0, regardless of state (reset mid-RUN aborts without capture).

Configuration
REQ-016 With RUN_CYCLE_CNT_EN defined, a 32-bit counter SHALL be readable at address 2+NUM_ARG_INS+NUM_ARG_OUTS: cleared on RUN entry, +1 per RUN cycle, frozen outside RUN, saturating at 0xFFFFFFFF, reset to 0.
REQ-017 Without RUN_CYCLE_CNT_EN, that address SHALL be unmapped (reads 0) and no counter logic exists.

Structure
REQ-018 Package arg_cmd_pkg SHALL hold address constants, status/command bit positions, and the state enum.
REQ-019 Arg storage and decode SHALL be one sub-module, arg_regfile; FSM and Avalon read mux remain in arg_cmd_ctrl.

Verification
REQ-020 Write addr2=0x4, addr0=0x1; done after 48 cycles with argOut0=0x10 -> read addr4=0x10, status=0x1, io_enable high exactly 48 cycles.
REQ-021 In RUN write addr2=0x9 -> addr2 still reads 0x4; write addr0=0x2 -> IDLE, status=0x0, argOut unchanged.
REQ-022 Abort write and io_done same cycle -> DONE, status=0x1, argOut captured.
REQ-023 Assert reset mid-RUN -> next cycle io_enable=0, all reads 0; read addr 0x7F -> 0.
REQ-024 RUN_CYCLE_CNT_EN defined, run 48 cycles -> addr5 reads 48; undefined -> addr5 reads 0.
REQ-025 Read with chipselect=0 -> readdata unchanged; status write 0x1 in DONE -> status=0x0, restart accepted.
